onebit_progmem: RTL and testbench
=================================

Name: onebit_progmem

Overview:
Program memory that answers the 1-bit CPU's instruction fetches: CPU drives `addr`, block returns instruction bit `data` combinationally in the same cycle.
- Program image is loaded serially through a valid/ready stream after reset or on request.
- `cpu_run` drives the CPU's active-low reset pin, so the CPU is held in reset until a complete image is resident.
- Sits between the boot/debug host stream and the CPU core.

Parameters:
- `ADDR_W`, default 1, width of the CPU fetch address; memory depth is `DEPTH = 2**ADDR_W` one-bit words.

Ports:
- `clock`  input  1  system clock, all state on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `addr`  input  ADDR_W  CPU fetch address.
- `data`  output  1  instruction bit at `addr`.
- `load_valid`  input  1  host offers `load_bit`.
- `load_bit`  input  1  serial program bit, address 0 first.
- `load_ready`  output  1  block accepts a bit this cycle.
- `reload`  input  1  single-cycle request to discard the image and reload.
- `cpu_run`  output  1  image valid; CPU released from reset.
- `load_err`  output  1  image rejected (parity build only; tied 0 otherwise).

Behaviour:
- One clock; reset is synchronous and active-high. On a reset edge:
  - memory cleared to all 0;
  - write pointer `wptr` = 0;
  - state = LOAD.
- Outputs after reset: `load_ready` = 1, `cpu_run` = 0, `data` = 0, `load_err` = 0.
- States:
  - LOAD:
    - `load_ready` = 1; `cpu_run` = 0; `data` = 0 (NOP, CPU accumulator held).
    - Transfer occurs when `load_valid` && `load_ready`: `mem[wptr]` <= `load_bit`, `wptr` += 1.
    - Transfer with `wptr` == DEPTH-1 → RUN.
    - No transfer → state and `wptr` unchanged (host may stall indefinitely).
  - RUN:
    - `load_ready` = 0; `cpu_run` = 1 (registered; first high the cycle after the final transfer).
    - `data` = `mem[addr]`, purely combinational, zero latency.
    - `load_valid` ignored.
  - ERR (parity build only):
    - `load_ready` = 0, `cpu_run` = 0, `data` = 0, `load_err` = 1.
    - Held until `reload` or `reset`.
- `reload` (any state): next state LOAD, `wptr` = 0, `cpu_run` = 0 next cycle, `load_err` cleared. Memory contents are not cleared; they are overwritten by the next load.
- Simultaneous `reload` and accepted transfer: `reload` wins, bit discarded, `wptr` = 0.
- `reset` asserted mid-load or mid-run: full reset as above; a partial image is never exposed.
- `wptr` is ADDR_W+1 bits wide. It never wraps: exit from LOAD occurs exactly at the last word.
- `addr` always indexes in range (DEPTH = 2**ADDR_W).

Optional Feature:
- Macro: `ONEBIT_PROGMEM_PARITY_EN`.
- Defined:
  - Image is DEPTH program bits followed by one extra parity bit; the parity transfer is accepted only when `wptr` == DEPTH.
  - A running XOR accumulates the program bits.
  - Parity bit == XOR → RUN.
  - Parity bit != XOR → ERR.
  - XOR is cleared on reset and reload.
- Undefined:
  - No parity bit, no ERR state, no XOR register; `load_err` tied 0.
  - Exit LOAD after DEPTH bits.

Decomposition:
- Shared package `onebit_pkg`:
  - state enum typedef `progmem_state_t` {LOAD, RUN, ERR};
  - constant `ONEBIT_ADDR_W` = 1 used as the default for CPU and memory.
- No sub-module warranted: storage array, pointer and FSM stay in one module.

Test Plan:
- ADDR_W=1, reset, then stream bits 1,0 with `load_valid` held high → exactly 2 transfers, `cpu_run` rises the cycle after the 2nd; `addr`=0 gives `data`=1, `addr`=1 gives `data`=0; `data`=0 throughout LOAD.
- Host toggles `load_valid` 1,0,0,1 with bits 1,x,x,1 → only 2 transfers counted; image {1,1}; no early `cpu_run`.
- In RUN, pulse `reload` while `load_valid`=1 → `cpu_run`=0 next cycle, `wptr`=0, offered bit not written; new stream 0,1 gives `mem[0]`=0, `mem[1]`=1.
- `reset` after 1 of 2 bits → `cpu_run` stays 0, memory all 0; a full reload is required before `cpu_run`=1.
- Integrated with the CPU, image {1,0}, 6 clocks of run → accumulator toggles only on cycles fetching address 0: A = 1,1,0,0,1,1.
- `ONEBIT_PROGMEM_PARITY_EN`: stream 1,0,parity 1 → RUN; stream 1,0,parity 0 → ERR, `load_err`=1, `cpu_run`=0; then `reload` clears `load_err`.

Source files
------------

// File: rtl/onebit_pkg.sv
// Shared definitions for the 1-bit CPU program memory.
//   progmem_state_t : loader state (LOAD, RUN, ERR)
//   ONEBIT_ADDR_W   : default fetch address width shared by CPU and memory
package onebit_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } progmem_state_t;

    localparam int ONEBIT_ADDR_W = 1;

endpackage

// File: rtl/onebit_progmem.sv
// Program memory for the 1-bit CPU.
// A serial image is streamed in over a valid/ready interface. Once it is
// complete the CPU is released from reset and its fetches are answered
// combinationally.
//
// Optional build macro: ONEBIT_PROGMEM_PARITY_EN. When it is defined, the
// image carries one trailing parity bit. That bit must equal the XOR of all
// program bits, and a mismatch parks the block in ERR.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   addr        in   CPU fetch address [ADDR_W-1:0]
//   data        out  instruction bit at addr (0 unless RUN)
//   load_valid  in   host offers load_bit
//   load_bit    in   serial image bit, address 0 first
//   load_ready  out  bit is accepted this cycle
//   reload      in   discard image and restart loading
//   cpu_run     out  image valid, CPU released from reset
//   load_err    out  parity failure (0 when parity is not built in)
//
// state | meaning
// LOAD  | accepting image bits, CPU held in reset, data forced to NOP
// RUN   | image resident, fetches served from memory
// ERR   | parity mismatch, CPU held in reset until reload/reset
module onebit_progmem
    import onebit_pkg::*;
#(
    parameter int ADDR_W = ONEBIT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic              data,
    input  logic              load_valid,
    input  logic              load_bit,
    output logic              load_ready,
    input  logic              reload,
    output logic              cpu_run,
    output logic              load_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] WPTR_LAST = (ADDR_W+1)'(DEPTH - 1);
`ifdef ONEBIT_PROGMEM_PARITY_EN
    localparam logic [ADDR_W:0] WPTR_PAR  = (ADDR_W+1)'(DEPTH);
`endif

    progmem_state_t    state_q, state_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [DEPTH-1:0]  mem_q, mem_d;
    logic              xfer;
`ifdef ONEBIT_PROGMEM_PARITY_EN
    logic              xor_q, xor_d;
`endif

    assign load_ready = (state_q == LOAD);
    assign cpu_run    = (state_q == RUN);
    assign data       = (state_q == RUN) ? mem_q[addr] : 1'b0;
    assign xfer       = load_valid && load_ready;
`ifdef ONEBIT_PROGMEM_PARITY_EN
    assign load_err   = (state_q == ERR);
`else
    assign load_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        mem_d   = mem_q;
`ifdef ONEBIT_PROGMEM_PARITY_EN
        xor_d   = xor_q;
`endif
        // reload takes priority over a transfer in the same cycle, so the
        // offered bit is dropped and the pointer restarts at 0
        if (reload) begin
            state_d = LOAD;
            wptr_d  = '0;
`ifdef ONEBIT_PROGMEM_PARITY_EN
            xor_d   = 1'b0;
`endif
        end else if (xfer) begin
`ifdef ONEBIT_PROGMEM_PARITY_EN
            if (wptr_q == WPTR_PAR) begin
                state_d = (load_bit == xor_q) ? RUN : ERR;
            end else begin
                mem_d[wptr_q[ADDR_W-1:0]] = load_bit;
                xor_d  = xor_q ^ load_bit;
                wptr_d = wptr_q + 1'b1;
            end
`else
            mem_d[wptr_q[ADDR_W-1:0]] = load_bit;
            wptr_d = wptr_q + 1'b1;
            if (wptr_q == WPTR_LAST) begin
                state_d = RUN;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LOAD;
            wptr_q  <= '0;
            mem_q   <= '0;
`ifdef ONEBIT_PROGMEM_PARITY_EN
            xor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            mem_q   <= mem_d;
`ifdef ONEBIT_PROGMEM_PARITY_EN
            xor_q   <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_onebit_progmem.sv
module tb_onebit_progmem;

    localparam int ADDR_W = 1;
    localparam int DEPTH  = 2**ADDR_W;

    typedef struct packed {
        logic rdy;
        logic run;
        logic dat;
        logic err;
    } obs_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] addr;
    logic              data;
    logic              load_valid;
    logic              load_bit;
    logic              load_ready;
    logic              reload;
    logic              cpu_run;
    logic              load_err;

    int n_cmp = 0;
    int n_mis = 0;

    obs_t sbq[$];

    // reference model
    int m_st;
    int m_wptr;
    int m_x;
    bit m_mem [DEPTH];

    always #5 clock = ~clock;

    onebit_progmem #(.ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .data       (data),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_ready (load_ready),
        .reload     (reload),
        .cpu_run    (cpu_run),
        .load_err   (load_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 1'b0;
        m_st = 0; m_wptr = 0; m_x = 0;
    endtask

    task automatic model_step(input bit lv, input bit lb, input bit rl, input bit rs);
        if (rs) begin
            model_reset();
        end else if (rl) begin
            m_st = 0; m_wptr = 0; m_x = 0;
        end else if (m_st == 0 && lv) begin
`ifdef ONEBIT_PROGMEM_PARITY_EN
            if (m_wptr == DEPTH) begin
                m_st = (int'(lb) == m_x) ? 1 : 2;
            end else begin
                m_mem[m_wptr] = lb;
                m_x = m_x ^ int'(lb);
                m_wptr++;
            end
`else
            m_mem[m_wptr] = lb;
            if (m_wptr == DEPTH-1) m_st = 1;
            m_wptr++;
`endif
        end
    endtask

    // one clock: drive, push expectation, sample/pop/compare, clock, model
    task automatic cycle(input bit lv, input bit lb, input bit rl, input bit rs,
                         input int a, output obs_t o);
        obs_t e, got;
        @(negedge clock);
        load_valid = lv; load_bit = lb; reload = rl; reset = rs;
        addr = ADDR_W'(a);
        e.rdy = (m_st == 0);
        e.run = (m_st == 1);
        e.dat = (m_st == 1) ? m_mem[a] : 1'b0;
        e.err = (m_st == 2);
        sbq.push_back(e);
        #1;
        got = '{rdy: load_ready, run: cpu_run, dat: data, err: load_err};
        e = sbq.pop_front();
        chk("load_ready", 32'(got.rdy), 32'(e.rdy));
        chk("cpu_run",    32'(got.run), 32'(e.run));
        chk("data",       32'(got.dat), 32'(e.dat));
        chk("load_err",   32'(got.err), 32'(e.err));
        o = got;
        @(posedge clock);
        model_step(lv, lb, rl, rs);
    endtask

    task automatic idle(input int a, output obs_t o);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, a, o);
    endtask

    // stream a 2-word image (plus its parity bit when built with parity)
    task automatic load_image(input bit b0, input bit b1);
        obs_t o;
        cycle(1'b1, b0, 1'b0, 1'b0, 0, o);
        cycle(1'b1, b1, 1'b0, 1'b0, 0, o);
`ifdef ONEBIT_PROGMEM_PARITY_EN
        chk("run_before_parity", 32'(o.run), 32'd0);
        cycle(1'b1, b0 ^ b1, 1'b0, 1'b0, 0, o);
`endif
    endtask

    initial begin
        obs_t o;
        bit   acc;
        bit   acc_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; load_valid = 1'b0; load_bit = 1'b0; reload = 1'b0; addr = '0;
        repeat (2) @(posedge clock);
        model_reset();

        // post-reset outputs
        idle(0, o);
        chk("rst_ready", 32'(o.rdy), 32'd1);
        chk("rst_run",   32'(o.run), 32'd0);
        chk("rst_data",  32'(o.dat), 32'd0);

        // image {1,0} with valid held high
        load_image(1'b1, 1'b0);
        idle(0, o);
        chk("img10_run",   32'(o.run), 32'd1);
        chk("img10_a0",    32'(o.dat), 32'd1);
        idle(1, o);
        chk("img10_a1",    32'(o.dat), 32'd0);

        // host stalls: valid 1,0,0,1 -> image {1,1}
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, o);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, o);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, o);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, o);
        chk("stall_norun", 32'(o.run), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, o);
`ifdef ONEBIT_PROGMEM_PARITY_EN
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, o);
`endif
        idle(0, o);
        chk("img11_a0", 32'(o.dat), 32'd1);
        idle(1, o);
        chk("img11_a1", 32'(o.dat), 32'd1);

        // reload with a bit on offer: bit dropped, then image {0,1}
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, o);
        idle(0, o);
        chk("reload_run", 32'(o.run), 32'd0);
        load_image(1'b0, 1'b1);
        idle(0, o);
        chk("img01_a0", 32'(o.dat), 32'd0);
        idle(1, o);
        chk("img01_a1", 32'(o.dat), 32'd1);

        // reset mid-load: partial image never exposed
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, o);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, o);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 0, o);
        for (int i = 0; i < 3; i++) begin
            idle(i % DEPTH, o);
            chk("midrst_run", 32'(o.run), 32'd0);
        end
        load_image(1'b1, 1'b0);

        // CPU-style run: accumulator toggles on each fetched 1
        acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(i % 2, o);
            acc = acc ^ o.dat;
            chk("acc", 32'(acc), 32'(acc_exp[i]));
        end

        // load_valid ignored in RUN
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1, o);
        idle(1, o);
        chk("run_ignore_lv", 32'(o.dat), 32'd0);

`ifdef ONEBIT_PROGMEM_PARITY_EN
        // bad parity -> ERR, held, then reload clears it
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, o);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, o);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, o);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, o);
        idle(0, o);
        chk("par_err",    32'(o.err), 32'd1);
        chk("par_err_run",32'(o.run), 32'd0);
        idle(0, o);
        chk("par_err_hold", 32'(o.err), 32'd1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, o);
        idle(0, o);
        chk("par_err_clr", 32'(o.err), 32'd0);
        chk("par_err_rdy", 32'(o.rdy), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
